// File: rtl/peak_readout_ctrl_pkg.sv
// peak_readout_ctrl_pkg: shared widths, host address map constants, FSM state
// type and the fixed signature bytes for the peak readout controller.
package peak_readout_ctrl_pkg;

  localparam int unsigned PEAKS              = 6;
  localparam int unsigned FREQ_WIDTH         = 8;
  localparam int unsigned AMPL_WIDTH         = 24;
  localparam int unsigned TIME_COUNTER_WIDTH = 32;
  localparam int unsigned FRAME_W = TIME_COUNTER_WIDTH + PEAKS * (FREQ_WIDTH + AMPL_WIDTH);

  localparam logic [7:0] ADDR_LOCK   = 8'hF0;
  localparam logic [7:0] ADDR_CLR    = 8'hF1;
  localparam logic [7:0] ADDR_DROP   = 8'd28;
  localparam logic [7:0] ADDR_STATUS = 8'd29;
  localparam logic [7:0] ADDR_SEQ    = 8'd30;
  localparam logic [7:0] ADDR_CONST0 = 8'd248;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWAP,
    ST_LOCKED,
    ST_LOCKED_PEND
  } state_e;

  // Signature bytes at the top of the address map.
  function automatic logic [7:0] const_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'd42;
      3'd1:    b = 8'd53;
      3'd2:    b = 8'd84;
      3'd3:    b = 8'd71;
      3'd4:    b = 8'd7;
      3'd5:    b = 8'd25;
      3'd6:    b = 8'd48;
      default: b = 8'd96;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/peak_readout_ctrl_frame_bank.sv
// peak_frame_bank: one frame-wide storage bank, loaded atomically on we_i.
//   clk, reset : clock and async active-high reset (clears the bank)
//   we_i       : load strobe
//   frame_i    : frame to store
//   frame_o    : stored frame
module peak_frame_bank #(
  parameter int unsigned FRAME_W = peak_readout_ctrl_pkg::FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic [FRAME_W-1:0] frame_o
);

  logic [FRAME_W-1:0] frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
    end else if (we_i) begin
      frame_q <= frame_i;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/peak_readout_ctrl.sv
// peak_readout_ctrl: double-buffered peak frame store with a host byte-read
// port. Frames land in the back bank; the front bank is shown to the host and
// can be frozen (locked) while new frames keep arriving.
//   clk, reset          : clock, async active-high reset
//   peaks_valid         : one-cycle strobe, new frame on counter_in/freqs_in/ampls_in
//   chipselect, write   : host select / write strobe
//   address, writedata  : host byte address / write data
//   readdata            : registered host read data (1-cycle latency)
module peak_readout_ctrl #(
  parameter int unsigned PEAKS              = peak_readout_ctrl_pkg::PEAKS,
  parameter int unsigned FREQ_WIDTH         = peak_readout_ctrl_pkg::FREQ_WIDTH,
  parameter int unsigned AMPL_WIDTH         = peak_readout_ctrl_pkg::AMPL_WIDTH,
  parameter int unsigned TIME_COUNTER_WIDTH = peak_readout_ctrl_pkg::TIME_COUNTER_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          peaks_valid,
  input  logic [TIME_COUNTER_WIDTH-1:0] counter_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0]   freqs_in,
  input  logic [PEAKS*AMPL_WIDTH-1:0]   ampls_in,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic [7:0]                    address,
  input  logic [7:0]                    writedata,
  output logic [7:0]                    readdata
);

  import peak_readout_ctrl_pkg::*;

  localparam int unsigned FRAME_BITS = TIME_COUNTER_WIDTH + PEAKS * (FREQ_WIDTH + AMPL_WIDTH);
  localparam int unsigned CNT_BYTES  = (TIME_COUNTER_WIDTH + 7) / 8;
  localparam int unsigned AMPL_BYTES = (AMPL_WIDTH + 7) / 8;
  localparam int unsigned FREQ_BASE  = CNT_BYTES;
  localparam int unsigned AMPL_BASE  = FREQ_BASE + PEAKS;

  state_e     state_q;
  logic       front_sel_q;
  logic       front_sel_d;
  logic       lock_req_q;
  logic [7:0] drop_q;
  logic [7:0] seq_q;

  logic [FRAME_BITS-1:0]         frame_in_c;
  logic [FRAME_BITS-1:0]         bank0_c, bank1_c, front_c;
  logic [TIME_COUNTER_WIDTH-1:0] front_cnt_c;
  logic [PEAKS*FREQ_WIDTH-1:0]   front_freqs_c;
  logic [PEAKS*AMPL_WIDTH-1:0]   front_ampls_c;
  logic                          swap_exit_c;
  logic                          drop_inc_c;
  logic                          host_wr_c;
  logic [7:0]                    map_c;
  logic                          unused_wdata_c;

  assign frame_in_c = {counter_in, freqs_in, ampls_in};
  assign host_wr_c  = chipselect & write;
  assign unused_wdata_c = ^writedata[7:1];

  // SWAP is left on every edge except "valid without lock", which re-enters SWAP.
  assign swap_exit_c = (state_q == ST_SWAP) && !(peaks_valid && !lock_req_q);
  assign front_sel_d = front_sel_q ^ swap_exit_c;
  assign drop_inc_c  = peaks_valid && (state_q == ST_SWAP || state_q == ST_LOCKED_PEND);

  // A captured frame always goes to the bank that is the back after this edge.
  peak_frame_bank #(.FRAME_W(FRAME_BITS)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (peaks_valid && front_sel_d),
    .frame_i (frame_in_c),
    .frame_o (bank0_c)
  );

  peak_frame_bank #(.FRAME_W(FRAME_BITS)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (peaks_valid && !front_sel_d),
    .frame_i (frame_in_c),
    .frame_o (bank1_c)
  );

  assign front_c       = front_sel_q ? bank1_c : bank0_c;
  assign front_cnt_c   = front_c[FRAME_BITS-1 -: TIME_COUNTER_WIDTH];
  assign front_freqs_c = front_c[PEAKS*(FREQ_WIDTH+AMPL_WIDTH)-1 -: PEAKS*FREQ_WIDTH];
  assign front_ampls_c = front_c[PEAKS*AMPL_WIDTH-1:0];

  // Host byte map of the front bank; multi-byte fields MSB first.
  always_comb begin
    map_c = 8'h00;
    for (int unsigned i = 0; i < CNT_BYTES; i++) begin
      if (address == 8'(i)) map_c = 8'(front_cnt_c >> (8 * (CNT_BYTES - 1 - i)));
    end
    for (int unsigned p = 0; p < PEAKS; p++) begin
      if (address == 8'(FREQ_BASE + p)) map_c = 8'(front_freqs_c[p*FREQ_WIDTH +: FREQ_WIDTH]);
      for (int unsigned b = 0; b < AMPL_BYTES; b++) begin
        if (address == 8'(AMPL_BASE + p * AMPL_BYTES + b))
          map_c = 8'(front_ampls_c[p*AMPL_WIDTH +: AMPL_WIDTH] >> (8 * (AMPL_BYTES - 1 - b)));
      end
    end
    if (address == ADDR_DROP)   map_c = drop_q;
    if (address == ADDR_STATUS) map_c = {6'b0, (state_q == ST_LOCKED || state_q == ST_LOCKED_PEND),
                                         (state_q == ST_LOCKED_PEND)};
    if (address == ADDR_SEQ)    map_c = seq_q;
    if (address >= ADDR_CONST0) map_c = const_byte(address[2:0]);
  end

  // Control FSM plus host-visible registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      front_sel_q <= 1'b0;
      lock_req_q  <= 1'b0;
      drop_q      <= 8'h00;
      seq_q       <= 8'h00;
      readdata    <= 8'h00;
    end else begin
      front_sel_q <= front_sel_d;
      if (swap_exit_c) seq_q <= seq_q + 8'd1;
      if (host_wr_c && address == ADDR_LOCK) lock_req_q <= writedata[0];
      // Clear wins over a same-cycle increment.
      if (host_wr_c && address == ADDR_CLR) drop_q <= 8'h00;
      else if (drop_inc_c && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      if (chipselect) readdata <= map_c;

      case (state_q)
        ST_IDLE: begin
          if (peaks_valid && lock_req_q) state_q <= ST_LOCKED_PEND;
          else if (peaks_valid)          state_q <= ST_SWAP;
          else if (lock_req_q)           state_q <= ST_LOCKED;
        end
        ST_SWAP: begin
          if (lock_req_q) state_q <= peaks_valid ? ST_LOCKED_PEND : ST_LOCKED;
          else            state_q <= peaks_valid ? ST_SWAP : ST_IDLE;
        end
        ST_LOCKED: begin
          if (peaks_valid)     state_q <= lock_req_q ? ST_LOCKED_PEND : ST_SWAP;
          else if (!lock_req_q) state_q <= ST_IDLE;
        end
        ST_LOCKED_PEND: begin
          if (!lock_req_q) state_q <= ST_SWAP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
